altera_up_audio_lj_master: RTL and testbench



---
 rtl/altera_up_audio_lj_master.sv | 200 ++++++++++++++++++++
 tb/tb_altera_up_audio_lj_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/altera_up_audio_lj_master.sv
// Master-mode left-justified audio serial interface: generates BCLK/LRCK, shifts one stereo
// DAC pair out and one stereo ADC pair in per frame.
module altera_up_audio_lj_master #(
  parameter int unsigned AUDIO_DATA_WIDTH = 16,
  parameter int unsigned SLOT_BITS        = 32,
  parameter int unsigned BCLK_DIV         = 4
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_data,
  input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_data,
  input  logic                        audio_out_valid,
  output logic                        audio_out_ready,
  output logic                        underflow,

  output logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio,
  output logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio,
  output logic                        audio_in_valid,

  input  logic                        AUD_ADCDAT,
  output logic                        AUD_BCLK,
  output logic                        AUD_DACLRCK,
  output logic                        AUD_ADCLRCK,
  output logic                        AUD_DACDAT
);

  localparam int unsigned W    = AUDIO_DATA_WIDTH;
  localparam int unsigned DivW = $clog2(BCLK_DIV);
  localparam int unsigned BitW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(BCLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(SLOT_BITS - 1);
  localparam logic [BitW-1:0] BitMsb   = BitW'(W - 1);
  localparam logic [BitW:0]   BitLimit = (BitW + 1)'(W);

  // Clock generation state
  logic [DivW-1:0] div_q, div_d;
  logic            bclk_q, bclk_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic            chan_q, chan_d;

  // Transmit path
  logic            hold_full_q, hold_full_d;
  logic [W-1:0]    hold_left_q, hold_left_d;
  logic [W-1:0]    hold_right_q, hold_right_d;
  logic [W-1:0]    tx_left_q, tx_left_d;
  logic [W-1:0]    tx_right_q, tx_right_d;
  logic            dacdat_q, dacdat_d;
  logic            underflow_q, underflow_d;
  logic            dac_bit;

  // Receive path
  logic            started_q, started_d;
  logic [W-1:0]    cap_left_q, cap_left_d;
  logic [W-1:0]    cap_right_q, cap_right_d;
  logic            copy_q, copy_d;
  logic [W-1:0]    out_left_q, out_left_d;
  logic [W-1:0]    out_right_q, out_right_d;
  logic            in_valid_q, in_valid_d;

  logic wrap, rise, fall, slot_end, frame_start, accept;
  logic [W-1:0] load_left, load_right;

  assign wrap        = (div_q == DivLast);
  assign rise        = wrap & ~bclk_q;
  assign fall        = wrap & bclk_q;
  assign slot_end    = (bit_q == BitLast);
  assign frame_start = fall & slot_end & ~chan_q;
  assign accept      = audio_out_valid & ~hold_full_q;
  assign load_left   = hold_full_q ? hold_left_q : '0;
  assign load_right  = hold_full_q ? hold_right_q : '0;

  always_comb begin
    div_d  = wrap ? '0 : div_q + DivW'(1);
    bclk_d = wrap ? ~bclk_q : bclk_q;
  end

  // Slot counter and DAC serializer; data changes together with LRCK on fall events.
  always_comb begin
    bit_d      = bit_q;
    chan_d     = chan_q;
    tx_left_d  = tx_left_q;
    tx_right_d = tx_right_q;
    dacdat_d   = dacdat_q;
    dac_bit    = 1'b0;
    if (fall) begin
      bit_d  = slot_end ? '0 : bit_q + BitW'(1);
      chan_d = slot_end ? ~chan_q : chan_q;
      if (frame_start) begin
        tx_left_d  = load_left;
        tx_right_d = load_right;
      end
      if (chan_d) begin
        dac_bit   = tx_left_d[W-1];
        tx_left_d = tx_left_d << 1;
      end else begin
        dac_bit    = tx_right_d[W-1];
        tx_right_d = tx_right_d << 1;
      end
      dacdat_d = dac_bit & ({1'b0, bit_d} < BitLimit);
    end
  end

  // A pair accepted on the frame-start cycle itself is held for the following frame.
  always_comb begin
    hold_full_d  = hold_full_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    underflow_d  = 1'b0;
    started_d    = started_q | frame_start;
    if (frame_start) begin
      if (hold_full_q) begin
        hold_full_d = 1'b0;
      end else begin
        underflow_d = 1'b1;
      end
    end
    if (accept) begin
      hold_full_d  = 1'b1;
      hold_left_d  = left_channel_data;
      hold_right_d = right_channel_data;
    end
  end

  // ADC deserializer; the pair is published one clk after the last right-channel bit.
  always_comb begin
    cap_left_d  = cap_left_q;
    cap_right_d = cap_right_q;
    copy_d      = 1'b0;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    in_valid_d  = copy_q;
    if (rise && started_q && ({1'b0, bit_q} < BitLimit)) begin
      if (chan_q) begin
        cap_left_d = (cap_left_q << 1) | W'(AUD_ADCDAT);
      end else begin
        cap_right_d = (cap_right_q << 1) | W'(AUD_ADCDAT);
      end
      copy_d = ~chan_q & (bit_q == BitMsb);
    end
    if (copy_q) begin
      out_left_d  = cap_left_q;
      out_right_d = cap_right_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      bclk_q       <= 1'b0;
      bit_q        <= BitLast;
      chan_q       <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
      tx_left_q    <= '0;
      tx_right_q   <= '0;
      dacdat_q     <= 1'b0;
      underflow_q  <= 1'b0;
      started_q    <= 1'b0;
      cap_left_q   <= '0;
      cap_right_q  <= '0;
      copy_q       <= 1'b0;
      out_left_q   <= '0;
      out_right_q  <= '0;
      in_valid_q   <= 1'b0;
    end else begin
      div_q        <= div_d;
      bclk_q       <= bclk_d;
      bit_q        <= bit_d;
      chan_q       <= chan_d;
      hold_full_q  <= hold_full_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      tx_left_q    <= tx_left_d;
      tx_right_q   <= tx_right_d;
      dacdat_q     <= dacdat_d;
      underflow_q  <= underflow_d;
      started_q    <= started_d;
      cap_left_q   <= cap_left_d;
      cap_right_q  <= cap_right_d;
      copy_q       <= copy_d;
      out_left_q   <= out_left_d;
      out_right_q  <= out_right_d;
      in_valid_q   <= in_valid_d;
    end
  end

  assign AUD_BCLK            = bclk_q;
  assign AUD_DACLRCK         = chan_q;
  assign AUD_ADCLRCK         = chan_q;
  assign AUD_DACDAT          = dacdat_q;
  assign audio_out_ready     = ~hold_full_q;
  assign underflow           = underflow_q;
  assign left_channel_audio  = out_left_q;
  assign right_channel_audio = out_right_q;
  assign audio_in_valid      = in_valid_q;

endmodule

// File: tb/tb_altera_up_audio_lj_master.sv
// Directed bench for the left-justified master with W=16, SLOT_BITS=16, BCLK_DIV=2.
module tb_altera_up_audio_lj_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] left_channel_data = '0;
  logic [15:0] right_channel_data = '0;
  logic        audio_out_valid = 1'b0;
  logic        audio_out_ready;
  logic        underflow;
  logic [15:0] left_channel_audio;
  logic [15:0] right_channel_audio;
  logic        audio_in_valid;
  logic        AUD_ADCDAT = 1'b0;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_ADCLRCK;
  logic        AUD_DACDAT;

  int n;
  int total = 0;
  int bad = 0;

  altera_up_audio_lj_master #(
    .AUDIO_DATA_WIDTH(16),
    .SLOT_BITS       (16),
    .BCLK_DIV        (2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .left_channel_data  (left_channel_data),
    .right_channel_data (right_channel_data),
    .audio_out_valid    (audio_out_valid),
    .audio_out_ready    (audio_out_ready),
    .underflow          (underflow),
    .left_channel_audio (left_channel_audio),
    .right_channel_audio(right_channel_audio),
    .audio_in_valid     (audio_in_valid),
    .AUD_ADCDAT         (AUD_ADCDAT),
    .AUD_BCLK           (AUD_BCLK),
    .AUD_DACLRCK        (AUD_DACLRCK),
    .AUD_ADCLRCK        (AUD_ADCLRCK),
    .AUD_DACDAT         (AUD_DACDAT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic step_to(input int t);
    while (n < t) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    audio_out_valid = 1'b0;
    AUD_ADCDAT = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic check_rst(input string p);
    check({p, " bclk"}, AUD_BCLK, 0);
    check({p, " daclrck"}, AUD_DACLRCK, 0);
    check({p, " adclrck"}, AUD_ADCLRCK, 0);
    check({p, " dacdat"}, AUD_DACDAT, 0);
    check({p, " ready"}, audio_out_ready, 1);
    check({p, " underflow"}, underflow, 0);
    check({p, " in_valid"}, audio_in_valid, 0);
    check({p, " left_audio"}, left_channel_audio, 0);
    check({p, " right_audio"}, right_channel_audio, 0);
  endtask

  // First BCLK rise at edge 2, first fall (frame start, underflow) at edge 4.
  task automatic idle_start(input string p);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("%s bclk e%0d", p, i), AUD_BCLK, (i == 2 || i == 3));
      check($sformatf("%s lrck e%0d", p, i), AUD_DACLRCK, (i == 4));
    end
    check({p, " underflow fs"}, underflow, 1);
    check({p, " dacdat fs"}, AUD_DACDAT, 0);
    check({p, " ready fs"}, audio_out_ready, 1);
    step();
    check({p, " underflow e5"}, underflow, 0);
  endtask

  // ADC bit the codec presents for the slot entered at edge t (4 clk per BCLK period).
  function automatic logic adc_bit(input int t);
    int f, b, fr;
    logic [15:0] l, r;
    if (t < 4) return 1'b1;
    f  = t / 4 - 1;
    b  = f % 16;
    fr = f / 32;
    l  = (fr == 0) ? 16'h1234 : 16'h8001;
    r  = (fr == 0) ? 16'hFEDC : 16'h7FFE;
    return ((f / 16) % 2 == 0) ? l[15-b] : r[15-b];
  endfunction

  initial begin
    logic [15:0] pl, pr;

    // Reset values, then idle timing with repeated underflow
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_rst("A rst");
    release_reset();
    idle_start("A");
    step_to(132);
    check("A underflow f2", underflow, 1);
    check("A lrck f2", AUD_DACLRCK, 1);
    step();
    check("A underflow f2+1", underflow, 0);
    step_to(260);
    check("A underflow f3", underflow, 1);

    // DAC pair offered before the first frame start
    do_reset();
    pl = 16'hA5C3;
    pr = 16'h0F01;
    left_channel_data  = pl;
    right_channel_data = pr;
    audio_out_valid    = 1'b1;
    step();
    audio_out_valid = 1'b0;
    check("B ready after accept", audio_out_ready, 0);
    step_to(3);
    check("B ready before load", audio_out_ready, 0);
    for (int f = 0; f < 32; f++) begin
      step_to(4 * (f + 1));
      check($sformatf("B dac f%0d", f), AUD_DACDAT, (f < 16) ? pl[15-f] : pr[31-f]);
      check($sformatf("B lrck f%0d", f), AUD_DACLRCK, (f < 16));
      check($sformatf("B adclrck f%0d", f), AUD_ADCLRCK, (f < 16));
      if (f == 0) begin
        check("B ready after load", audio_out_ready, 1);
        check("B no underflow", underflow, 0);
      end
    end
    step_to(132);
    check("B underflow f2", underflow, 1);
    check("B dac f2", AUD_DACDAT, 0);

    // ADC capture over two frames
    do_reset();
    for (int t = 0; t < 262; t++) begin
      AUD_ADCDAT = adc_bit(n);
      step();
      check($sformatf("C in_valid e%0d", n), audio_in_valid, (n == 131 || n == 259));
      if (n == 130) begin
        check("C left before", left_channel_audio, 16'h0000);
        check("C right before", right_channel_audio, 16'h0000);
      end
      if (n == 131) begin
        check("C left f1", left_channel_audio, 16'h1234);
        check("C right f1", right_channel_audio, 16'hFEDC);
      end
      if (n == 259) begin
        check("C left f2", left_channel_audio, 16'h8001);
        check("C right f2", right_channel_audio, 16'h7FFE);
      end
    end

    // Offer exactly on the frame-start cycle: zeros now, pair next frame
    do_reset();
    pl = 16'h3C5A;
    pr = 16'h8001;
    step_to(3);
    left_channel_data  = pl;
    right_channel_data = pr;
    audio_out_valid    = 1'b1;
    step();
    audio_out_valid = 1'b0;
    check("D underflow", underflow, 1);
    check("D ready", audio_out_ready, 0);
    check("D dac f0", AUD_DACDAT, 0);
    for (int f = 1; f < 64; f++) begin
      step_to(4 * (f + 1));
      if (f < 32)
        check($sformatf("D dac zero f%0d", f), AUD_DACDAT, 0);
      else
        check($sformatf("D dac f%0d", f), AUD_DACDAT, (f < 48) ? pl[47-f] : pr[63-f]);
      if (f == 32) begin
        check("D underflow f2", underflow, 0);
        check("D ready f2", audio_out_ready, 1);
      end
    end

    // Reset mid-transfer with a second pair held
    do_reset();
    left_channel_data  = 16'hA5C3;
    right_channel_data = 16'h0F01;
    audio_out_valid    = 1'b1;
    step();
    audio_out_valid = 1'b0;
    step_to(5);
    left_channel_data  = 16'h1111;
    right_channel_data = 16'h2222;
    audio_out_valid    = 1'b1;
    step();
    audio_out_valid = 1'b0;
    step_to(70);
    check("E ready held", audio_out_ready, 0);
    check("E bclk e70", AUD_BCLK, 1);
    reset = 1'b1;
    #1;
    check_rst("E rst");
    release_reset();
    idle_start("E2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
